// File: rtl/memory_access_stage.sv
// memory_access_stage
// Memory-stage load/store unit. Issues the EX/MEM instruction's load or store
// on a req/gnt/rvalid data bus, builds byte enables and lane-replicated store
// data, formats returning load data, stalls the pipeline while the access is
// outstanding, and reports misaligned accesses and bus timeouts as pulses.
module memory_access_stage #(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_gnt,
    input  logic        dbus_rvalid,
    input  logic [31:0] dbus_rdata,
    output logic [31:0] RdataM,
    output logic        StallM,
    output logic        MisalignM,
    output logic        BusFaultM
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    localparam logic [1:0] ST_IDLE        = 2'd0;
    localparam logic [1:0] ST_WAIT_GNT    = 2'd1;
    localparam logic [1:0] ST_WAIT_RVALID = 2'd2;

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_WAIT);

    logic [1:0]    r_state;
    logic [CW-1:0] r_wait_cnt;

    logic [1:0]    w_next_state;
    logic [CW-1:0] w_next_cnt;
    logic          w_pending;
    logic          w_aligned;
    logic          w_drive;
    logic          w_is_store;
    logic          w_in_wait;
    logic          w_complete;
    logic          w_fault;

    // Byte enables for a store of the given size at the given byte offset.
    function automatic logic [3:0] f_store_be(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data replicated across every lane the access could target.
    function automatic logic [31:0] f_store_data(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] data;
        case (size)
            2'b00:   data = {4{wd[7:0]}};
            2'b01:   data = {2{wd[15:0]}};
            default: data = wd;
        endcase
        return data;
    endfunction

    // Lane selection plus sign or zero extension of a full-word read.
    function automatic logic [31:0] f_format_load(input logic [2:0] f3, input logic [1:0] off,
                                                  input logic [31:0] rd);
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        logic [31:0] res;
        case (off)
            2'b00:   lane_b = rd[7:0];
            2'b01:   lane_b = rd[15:8];
            2'b10:   lane_b = rd[23:16];
            default: lane_b = rd[31:24];
        endcase
        lane_h = off[1] ? rd[31:16] : rd[15:0];
        case (f3[1:0])
            2'b00:   res = f3[2] ? {24'h000000, lane_b} : {{24{lane_b[7]}}, lane_b};
            2'b01:   res = f3[2] ? {16'h0000, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: res = rd;
        endcase
        return res;
    endfunction

    // Access qualification: alignment by size, and bus-level completion/timeout events.
    always_comb begin
        w_pending  = MemReadM | MemWriteM;
        w_is_store = MemWriteM;
        case (Funct3M[1:0])
            2'b00:   w_aligned = 1'b1;
            2'b01:   w_aligned = ~ALUResultM[0];
            default: w_aligned = (ALUResultM[1:0] == 2'b00);
        endcase
        // Upstream holds EX/MEM stable while stalled, so the same qualification
        // stays valid for the whole lifetime of the access.
        w_drive    = ~rst & w_pending & w_aligned;
        w_in_wait  = (r_state == ST_WAIT_GNT) | (r_state == ST_WAIT_RVALID);
        w_complete = ~rst & (r_state == ST_WAIT_RVALID) & dbus_rvalid;
        // Completion on the last allowed cycle still counts as success.
        w_fault    = ~rst & w_in_wait & (r_wait_cnt == CNT_MAX) & ~w_complete;
    end

    // Bus-side request, address, enables and write data.
    always_comb begin
        if (w_drive) begin
            dbus_req   = (r_state == ST_IDLE) | ((r_state == ST_WAIT_GNT) & ~w_fault);
            dbus_we    = w_is_store;
            dbus_addr  = {ALUResultM[31:2], 2'b00};
            dbus_be    = w_is_store ? f_store_be(Funct3M[1:0], ALUResultM[1:0]) : 4'b1111;
            dbus_wdata = w_is_store ? f_store_data(Funct3M[1:0], WriteDataM) : 32'h00000000;
        end else begin
            dbus_req   = 1'b0;
            dbus_we    = 1'b0;
            dbus_addr  = 32'h00000000;
            dbus_be    = 4'b0000;
            dbus_wdata = 32'h00000000;
        end
    end

    // Pipeline-side stall, formatted load data and status pulses.
    always_comb begin
        StallM    = w_drive & ~w_complete & ~w_fault;
        MisalignM = ~rst & (r_state == ST_IDLE) & w_pending & ~w_aligned;
        BusFaultM = w_fault;
        if (w_complete & MemReadM & ~MemWriteM) begin
            RdataM = f_format_load(Funct3M, ALUResultM[1:0], dbus_rdata);
        end else begin
            RdataM = 32'h00000000;
        end
    end

    // Next state and timeout counter.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_wait_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_drive) begin
                    w_next_state = dbus_gnt ? ST_WAIT_RVALID : ST_WAIT_GNT;
                    // The issue cycle itself counts towards the wait budget.
                    w_next_cnt   = CNT_ONE;
                end else begin
                    w_next_cnt   = CNT_ZERO;
                end
            end
            ST_WAIT_GNT: begin
                if (w_fault) begin
                    w_next_state = ST_IDLE;
                    w_next_cnt   = CNT_ZERO;
                end else if (dbus_gnt) begin
                    w_next_state = ST_WAIT_RVALID;
                    w_next_cnt   = r_wait_cnt + CNT_ONE;
                end else begin
                    w_next_cnt   = r_wait_cnt + CNT_ONE;
                end
            end
            ST_WAIT_RVALID: begin
                if (w_complete | w_fault) begin
                    w_next_state = ST_IDLE;
                    w_next_cnt   = CNT_ZERO;
                end else begin
                    w_next_cnt   = r_wait_cnt + CNT_ONE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_cnt   = CNT_ZERO;
            end
        endcase
    end

    // State register with synchronous reset; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= CNT_ZERO;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_next_cnt;
        end
    end

endmodule

// File: tb/tb_memory_access_stage.sv
// Self-checking bench for memory_access_stage: directed scenarios from the
// test plan plus randomized accesses, all checked against a cycle-level
// reference model built from size/offset arithmetic.
module tb_memory_access_stage;

    localparam int MAXW = 4;

    logic        clk;
    logic        rst;
    logic        MemReadM;
    logic        MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        dbus_gnt;
    logic        dbus_rvalid;
    logic [31:0] dbus_rdata;
    logic [31:0] RdataM;
    logic        StallM;
    logic        MisalignM;
    logic        BusFaultM;

    int checks   = 0;
    int failures = 0;

    memory_access_stage #(.MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
        .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
        .RdataM(RdataM), .StallM(StallM), .MisalignM(MisalignM), .BusFaultM(BusFaultM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int nbytes_of(input logic [2:0] f3);
        return f3[1] ? 4 : (f3[0] ? 2 : 1);
    endfunction

    function automatic bit is_aligned(input logic [2:0] f3, input logic [31:0] a);
        int off;
        off = int'(a[1:0]);
        return (off % nbytes_of(f3)) == 0;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
        int n;
        int off;
        logic [63:0] m;
        logic [63:0] v;
        n   = nbytes_of(f3);
        off = (n == 4) ? 0 : int'(a[1:0]);
        m   = (64'd1 << (8 * n)) - 64'd1;
        v   = ({32'h00000000, rd} >> (8 * off)) & m;
        if (!f3[2] && n < 4 && v[8 * n - 1]) v = v | ~m;
        return v[31:0];
    endfunction

    function automatic logic [3:0] exp_be(input logic wr, input logic [2:0] f3,
                                          input logic [31:0] a);
        int bm;
        if (!wr) return 4'hF;
        bm = ((1 << nbytes_of(f3)) - 1) << int'(a[1:0]);
        return bm[3:0];
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] res;
        int n;
        n = nbytes_of(f3);
        for (int i = 0; i < 4; i++) res[8 * i +: 8] = wd[8 * (i % n) +: 8];
        return res;
    endfunction

    // ---------------- stimulus primitives ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        MemReadM   = 1'b0;
        MemWriteM  = 1'b0;
        Funct3M    = 3'd0;
        ALUResultM = $urandom;
        WriteDataM = $urandom;
        dbus_gnt   = 1'b0;
        dbus_rvalid = 1'b0;
        dbus_rdata = $urandom;
    endtask

    // One aligned access: gnt arrives in cycle g, rvalid r cycles after grant.
    // Entered just after a rising edge; leaves just after the edge ending the access.
    task automatic run_access(input string nm, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input int g, input int r,
                              input logic [31:0] rdat);
        int c;
        int e;
        bit faulted;
        bit is_load;
        logic [31:0] lv;
        logic exp_req;
        logic exp_stall;
        logic [31:0] exp_rd;
        c       = g + 1 + r;
        faulted = (c > MAXW);
        e       = faulted ? MAXW : c;
        is_load = rd && !wr;
        lv      = exp_load(f3, a, rdat);
        for (int k = 0; k <= e; k++) begin
            MemReadM    = rd;
            MemWriteM   = wr;
            Funct3M     = f3;
            ALUResultM  = a;
            WriteDataM  = wd;
            dbus_gnt    = (k == g);
            dbus_rvalid = (k == c);
            dbus_rdata  = (k == c) ? rdat : $urandom;
            @(negedge clk);
            exp_req   = (k <= g) && !(faulted && k == e);
            exp_stall = (k != e);
            exp_rd    = (!faulted && k == e && is_load) ? lv : 32'h0;
            checks++;
            if (dbus_req !== exp_req) begin
                failures++;
                $display("FAIL %s req cyc%0d: got %b exp %b", nm, k, dbus_req, exp_req);
            end
            checks++;
            if (StallM !== exp_stall) begin
                failures++;
                $display("FAIL %s stall cyc%0d: got %b exp %b", nm, k, StallM, exp_stall);
            end
            checks++;
            if (RdataM !== exp_rd) begin
                failures++;
                $display("FAIL %s rdata cyc%0d: got %h exp %h", nm, k, RdataM, exp_rd);
            end
            checks++;
            if (BusFaultM !== (faulted && k == e) || MisalignM !== 1'b0) begin
                failures++;
                $display("FAIL %s flags cyc%0d: fault %b misalign %b exp fault %b",
                         nm, k, BusFaultM, MisalignM, faulted && k == e);
            end
            if (k <= g && k < e) begin
                checks++;
                if (dbus_addr !== (a - {30'd0, a[1:0]}) || dbus_we !== wr ||
                    dbus_be !== exp_be(wr, f3, a) ||
                    (wr && dbus_wdata !== exp_wdata(f3, wd))) begin
                    failures++;
                    $display("FAIL %s bus cyc%0d: addr %h we %b be %b wdata %h exp addr %h we %b be %b wdata %h",
                             nm, k, dbus_addr, dbus_we, dbus_be, dbus_wdata,
                             a - {30'd0, a[1:0]}, wr, exp_be(wr, f3, a), exp_wdata(f3, wd));
                end
            end
            next_cycle();
        end
        dbus_gnt    = 1'b0;
        dbus_rvalid = 1'b0;
    endtask

    // One misaligned access, which must be rejected in a single cycle.
    task automatic run_misalign(input string nm, input logic rd, input logic wr,
                                input logic [2:0] f3, input logic [31:0] a);
        MemReadM    = rd;
        MemWriteM   = wr;
        Funct3M     = f3;
        ALUResultM  = a;
        WriteDataM  = $urandom;
        dbus_gnt    = 1'b1;
        dbus_rvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (dbus_req !== 1'b0 || MisalignM !== 1'b1 || StallM !== 1'b0 ||
            RdataM !== 32'h0 || BusFaultM !== 1'b0) begin
            failures++;
            $display("FAIL %s: req %b misalign %b stall %b rdata %h fault %b exp 0 1 0 0 0",
                     nm, dbus_req, MisalignM, StallM, RdataM, BusFaultM);
        end
        next_cycle();
        dbus_gnt = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        MemReadM = 1'b1; MemWriteM = 1'b1; Funct3M = 3'b010;
        ALUResultM = 32'h100; WriteDataM = 32'h12345678;
        dbus_gnt = 1'b1; dbus_rvalid = 1'b1; dbus_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        checks++;
        if (dbus_req !== 1'b0 || StallM !== 1'b0 || MisalignM !== 1'b0 || BusFaultM !== 1'b0 ||
            RdataM !== 32'h0 || dbus_we !== 1'b0 || dbus_be !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs: req %b stall %b mis %b flt %b rdata %h we %b be %b exp all 0",
                     dbus_req, StallM, MisalignM, BusFaultM, RdataM, dbus_we, dbus_be);
        end
        next_cycle();
        next_cycle();
        rst = 1'b0;
        drive_idle();
    endtask

    task automatic test_idle();
        for (int i = 0; i < 3; i++) begin
            drive_idle();
            dbus_gnt    = 1'($urandom);
            dbus_rvalid = 1'($urandom);
            @(negedge clk);
            checks++;
            if (dbus_req !== 1'b0 || StallM !== 1'b0 || MisalignM !== 1'b0 || BusFaultM !== 1'b0 ||
                RdataM !== 32'h0 || dbus_we !== 1'b0 || dbus_be !== 4'b0000) begin
                failures++;
                $display("FAIL idle_outputs: req %b stall %b mis %b flt %b rdata %h we %b be %b",
                         dbus_req, StallM, MisalignM, BusFaultM, RdataM, dbus_we, dbus_be);
            end
            next_cycle();
        end
    endtask

    task automatic test_load_word();
        run_access("lw_min", 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF);
    endtask

    task automatic test_load_format();
        run_access("lb",  1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 0, 0, 32'h80FF1234);
        run_access("lbu", 1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 0, 0, 32'h80FF1234);
        run_access("lh",  1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 0, 0, 32'h80FF1234);
        run_access("lhu", 1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 0, 0, 32'h80FF1234);
    endtask

    task automatic test_store_delay();
        // Grant arrives three cycles late; ack lands on the last permitted cycle.
        run_access("sb_delay", 1'b0, 1'b1, 3'b000, 32'h201, 32'h000000AB, 3, 0, 32'h0);
        run_access("sh_both",  1'b1, 1'b1, 3'b001, 32'h302, 32'hCAFE1357, 1, 1, 32'h11223344);
    endtask

    task automatic test_misalign();
        run_misalign("mis_lw", 1'b1, 1'b0, 3'b010, 32'h102);
        run_misalign("mis_sh", 1'b0, 1'b1, 3'b001, 32'h101);
    endtask

    task automatic test_timeout();
        run_access("timeout", 1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 0, 50, 32'h0);
        drive_idle();
        dbus_rvalid = 1'b1;
        @(negedge clk);
        checks++;
        if (RdataM !== 32'h0 || StallM !== 1'b0 || BusFaultM !== 1'b0 || dbus_req !== 1'b0) begin
            failures++;
            $display("FAIL late_rvalid: rdata %h stall %b fault %b req %b exp 0",
                     RdataM, StallM, BusFaultM, dbus_req);
        end
        next_cycle();
        run_access("lw_after_fault", 1'b1, 1'b0, 3'b010, 32'h504, 32'h0, 0, 0, 32'h0BADF00D);
    endtask

    task automatic test_reset_mid();
        MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'b010;
        ALUResultM = 32'h300; dbus_gnt = 1'b1; dbus_rvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (dbus_req !== 1'b1 || StallM !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_issue: req %b stall %b exp 1 1", dbus_req, StallM);
        end
        next_cycle();
        rst = 1'b1;
        dbus_gnt = 1'b0;
        @(negedge clk);
        checks++;
        if (dbus_req !== 1'b0 || StallM !== 1'b0 || RdataM !== 32'h0) begin
            failures++;
            $display("FAIL rst_mid_hold: req %b stall %b rdata %h exp 0", dbus_req, StallM, RdataM);
        end
        next_cycle();
        rst = 1'b0;
        drive_idle();
        dbus_rvalid = 1'b1;
        dbus_rdata  = 32'hA5A5A5A5;
        @(negedge clk);
        checks++;
        if (dbus_req !== 1'b0 || StallM !== 1'b0 || RdataM !== 32'h0 || BusFaultM !== 1'b0) begin
            failures++;
            $display("FAIL rst_stale_rvalid: req %b stall %b rdata %h fault %b exp 0",
                     dbus_req, StallM, RdataM, BusFaultM);
        end
        next_cycle();
        run_access("sw_after_rst", 1'b0, 1'b1, 3'b010, 32'h400, 32'h89ABCDEF, 0, 0, 32'h0);
    endtask

    task automatic test_back_to_back();
        run_access("b2b_0", 1'b1, 1'b0, 3'b010, 32'h600, 32'h0, 0, 0, 32'h01020304);
        run_access("b2b_1", 1'b0, 1'b1, 3'b001, 32'h606, 32'h0000BEEF, 0, 2, 32'h0);
        run_access("b2b_2", 1'b1, 1'b0, 3'b000, 32'h609, 32'h0, 2, 0, 32'hFEDC8A98);
    endtask

    task automatic test_random();
        logic [2:0] f3_tab [5];
        logic [2:0] f3;
        logic [31:0] a;
        logic rd;
        logic wr;
        f3_tab[0] = 3'b000; f3_tab[1] = 3'b001; f3_tab[2] = 3'b010;
        f3_tab[3] = 3'b100; f3_tab[4] = 3'b101;
        for (int i = 0; i < 60; i++) begin
            f3 = f3_tab[$urandom_range(0, 4)];
            a  = $urandom;
            rd = 1'($urandom);
            wr = 1'($urandom);
            if (!rd && !wr) rd = 1'b1;
            if (is_aligned(f3, a)) begin
                run_access("rand", rd, wr, f3, a, $urandom,
                           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom);
            end else begin
                run_misalign("rand_mis", rd, wr, f3, a);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_idle();
        rst = 1'b1;
        next_cycle();
        test_reset();
        test_idle();
        test_load_word();
        test_load_format();
        test_store_delay();
        test_misalign();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_access_stage.md
# memory_access_stage

Memory-stage load/store unit between the EX/MEM register and the MEM/WB register. It issues the current instruction's load or store on a req/gnt/rvalid data bus and generates byte enables and replicated store data. It formats load data with sign or zero extension, stalls the pipeline until the bus access completes, and flags misaligned accesses and bus timeouts. RdataM feeds the MEM/WB register directly.

## Interface
- MAX_WAIT, 255: cycles an access may remain outstanding before it is aborted with BusFaultM; must be ≥2.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- MemReadM  in  1  load in memory stage
- MemWriteM  in  1  store in memory stage; wins if both MemReadM and MemWriteM are set
- Funct3M  in  3  [1:0]: 00 byte, 01 half, 1x word; [2]: zero-extend load
- ALUResultM  in  32  byte address
- WriteDataM  in  32  store data (rs2)
- dbus_req  out  1  bus request
- dbus_we  out  1  1 = write
- dbus_addr  out  32  {ALUResultM[31:2], 2'b00}
- dbus_be  out  4  byte enables
- dbus_wdata  out  32  lane-replicated store data
- dbus_gnt  in  1  request accepted this cycle
- dbus_rvalid  in  1  response (read data or write ack)
- dbus_rdata  in  32  read data, valid with rvalid
- RdataM  out  32  formatted load data; 0 unless a load completes this cycle
- StallM  out  1  hold IF..MEM, bubble MEM/WB
- MisalignM  out  1  misaligned access, 1-cycle pulse
- BusFaultM  out  1  timeout abort, 1-cycle pulse

## Operation
- Access pending = MemReadM | MemWriteM. Misaligned = half with addr[0]=1, or word with addr[1:0]≠0.
- FSM states: IDLE, WAIT_GNT, WAIT_RVALID.
- IDLE, pending & aligned:
  - dbus_req=1 combinationally.
  - gnt=1 → WAIT_RVALID; gnt=0 → WAIT_GNT.
- IDLE, pending & misaligned:
  - No request.
  - MisalignM=1, StallM=0, RdataM=0, stay IDLE.
- WAIT_GNT:
  - dbus_req=1; address, be and wdata held.
  - gnt → WAIT_RVALID.
- WAIT_RVALID:
  - dbus_req=0.
  - rvalid → completion cycle: StallM=0, RdataM valid for loads, next state IDLE.
- StallM = pending & aligned & not (completion or fault) in the current cycle.
- Upstream holds the EX/MEM inputs stable while StallM=1. The FSM relies on this.
- Byte enables and store data:
  - byte: be = 4'b0001<<addr[1:0], wdata = {4{WriteDataM[7:0]}}
  - half: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{WriteDataM[15:0]}}
  - word: be = 4'b1111, wdata = WriteDataM
- Loads: lane is selected by addr[1:0]. Sign-extend when Funct3M[2]=0, else zero-extend. The bus is always read as a full word with be=4'b1111.
- Timeout:
  - wait_cnt is cleared when the request first asserts from IDLE and increments each cycle in WAIT_GNT or WAIT_RVALID. Width is $clog2(MAX_WAIT+1).
  - If wait_cnt==MAX_WAIT without completion: BusFaultM=1, StallM=0, RdataM=0, dbus_req=0, next state IDLE.
  - A faulting store may or may not have been written.
- Stray responses:
  - rvalid in IDLE or WAIT_GNT is ignored.
  - A late rvalid after a fault or reset is ignored.

## Timing
- Reset (rst=1 at the clk edge): state IDLE, wait_cnt 0.
- While rst=1: dbus_req=0, StallM=0, MisalignM=0, BusFaultM=0, RdataM=0, dbus_we=0, dbus_be=0.
- Reset during an access abandons it. No replay.
- Minimum latency: gnt in the issue cycle and rvalid the next cycle gives 2 cycles, with StallM high for exactly 1 cycle.
- Each extra cycle without gnt or rvalid adds 1 stall cycle.
- Back-to-back accesses: the next instruction may issue in the cycle after completion, because state is IDLE. No dead cycle beyond that.
- dbus_req, StallM and RdataM are combinational from inputs and state. All state updates occur on the rising clk edge.
- Non-memory instruction in IDLE: all outputs 0. No state change.

## Test plan
- LW at 0x100, gnt same cycle, rvalid+rdata=0xDEADBEEF next cycle → StallM 1 cycle; be=1111, addr 0x100; RdataM=0xDEADBEEF in the rvalid cycle.
- LB at 0x103 with rdata 0x80FF1234 → RdataM=0xFFFFFF80. LBU at the same address → 0x00000080. LH at 0x102 → 0xFFFF80FF. LHU at 0x102 → 0x000080FF.
- SB at 0x0201, WriteDataM=0x000000AB, gnt delayed 3 cycles → req held 4 cycles; be=0010, wdata=0xABABABAB, dbus_we=1; StallM low only on the ack cycle.
- LW at 0x102 and SH at 0x101 → no dbus_req; MisalignM pulse; StallM=0 in the same cycle.
- MAX_WAIT=4, gnt given but rvalid never arrives → BusFaultM pulse on the 5th cycle of the access. Return to IDLE. A subsequent rvalid is ignored, and the next LW completes normally.
- rst asserted in WAIT_RVALID → outputs zero next cycle; stale rvalid ignored; fresh SW after reset issues at once.
